btn_event_arbiter: RTL

//  Front end for the ATM push-button keypad. Debounces N active-low raw buttons and

---
 rtl/atm_btn_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 52 +++++
 rtl/btn_event_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/atm_btn_pkg.sv
// Shared constants and types for the ATM push-button keypad front end.
package atm_btn_pkg;

   localparam int N_BTN          = 4;
   localparam int IDW            = $clog2(N_BTN);
   localparam int FIFO_DEPTH     = 4;
   localparam int DEB_CYCLES_HW  = 5_000_000;   // 50 ms at 100 MHz
   localparam int DEB_CYCLES_SIM = 8;           // short debounce window for simulation

   typedef logic [IDW-1:0] btn_id_t;

   // Increment an index and wrap it back to zero at n (n need not be a power of 2).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, arm flag, saturating stable-low
// counter and a single-cycle registered press pulse per accepted press.
module btn_debounce_ch
   import atm_btn_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_HW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);

   localparam int              CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_FIRE = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(DEB_CYCLES);

   logic [1:0]    sync;
   logic          btn_s;
   logic          armed;
   logic [CW-1:0] cnt;

   // Synchroniser; resets to the pressed level so a key held through reset reads as
   // pressed and the channel cannot arm until it is seen released.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b00;
      else        sync <= {sync[0], btn_n};
   end

   assign btn_s = ~sync[1];

   // Arm on the first released cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      armed <= 1'b0;
      else if (!btn_s) armed <= 1'b1;
   end

   // Count consecutive pressed cycles; clear on release, saturate instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt <= '0;
      else if (!btn_s)                  cnt <= '0;
      else if (armed && cnt != CNT_MAX) cnt <= cnt + 1'b1;
   end

   // Fire once when the count passes the debounce threshold; saturation blocks repeats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) press <= 1'b0;
      else        press <= btn_s && armed && (cnt == CNT_FIRE);
   end

endmodule

// File: rtl/btn_event_arbiter.sv
// Keypad front end: N debounce channels, per-button pending flags, a round-robin
// arbiter and a small event FIFO drained through a valid/ready port.
module btn_event_arbiter #(
   parameter int N_BTN      = atm_btn_pkg::N_BTN,
   parameter int DEB_CYCLES = atm_btn_pkg::DEB_CYCLES_HW,
   parameter int FIFO_DEPTH = atm_btn_pkg::FIFO_DEPTH,
   parameter int IDW        = $clog2(N_BTN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_n,
   output logic             evt_valid,
   output logic [IDW-1:0]   evt_id,
   input  logic             evt_ready,
   output logic             evt_overflow,
   input  logic             clr_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] pend;
   logic [N_BTN-1:0] pend_nxt;
   logic [N_BTN-1:0] grant;
   logic [N_BTN-1:0] drop;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant_idx;
   logic             grant_valid;

   logic [IDW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             push;
   logic             pop;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .btn_n (btn_n[i]),
         .press (press[i])
      );
   end

   // Full decodes the registered count, so a pop in the same cycle never frees a slot.
   assign full = (count == (AW+1)'(FIFO_DEPTH));
   assign push = grant_valid;
   assign pop  = evt_valid && evt_ready;

   // Round-robin search from rr_ptr for the first pending button.
   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      if (!full) begin
         for (int k = 0; k < N_BTN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (!grant_valid && pend[idx]) begin
               grant_valid = 1'b1;
               grant_idx   = IDW'(idx);
               grant[idx]  = 1'b1;
            end
         end
      end
   end

   // A new press always wins over a grant; a press onto an ungranted pending flag is lost.
   always_comb begin
      pend_nxt = (pend & ~grant) | press;
      drop     = press & pend & ~grant;
   end

   // Pending flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= '0;
      else        pend <= pend_nxt;
   end

   // Round-robin pointer moves just past the button that was served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           rr_ptr <= '0;
      else if (grant_valid) rr_ptr <= IDW'(atm_btn_pkg::wrap_inc(int'(grant_idx), N_BTN));
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            evt_overflow <= 1'b0;
      else if (|drop)        evt_overflow <= 1'b1;
      else if (clr_overflow) evt_overflow <= 1'b0;
   end

   // FIFO storage.
   // NOTE: the entry array has no reset; pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= grant_idx;
   end

   // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign evt_valid = (count != '0);
   assign evt_id    = evt_valid ? mem[rd_ptr] : '0;

endmodule
